// File: rtl/ex_muldiv_ctrl.sv
// RV32M execute unit: 32-step shift-add multiply / restoring divide with pipeline stall control.
// Divide-by-zero and signed overflow results bypass the iteration and retire one cycle after start.
module ex_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        busy_o,
  output logic [31:0] result_o,
  output logic        result_valid_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [31:0] hi_q, lo_q, opb_q;
  logic        neg_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q, waddr_q;

  logic        in_div, s1, s2, neg_in, op2_zero, ovf, fast;
  logic [31:0] mag1, mag2, fast_res;

  // Decode of the incoming instruction, used only on acceptance in StIdle.
  always_comb begin
    in_div   = funct3_i[2];
    s1       = op1_i[31] & (in_div ? ~funct3_i[0]
                                   : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10));
    s2       = op2_i[31] & (in_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01));
    mag1     = s1 ? -op1_i : op1_i;
    mag2     = s2 ? -op2_i : op2_i;
    // Remainder follows the dividend's sign; quotient and product follow the sign XOR.
    neg_in   = (in_div & funct3_i[1]) ? s1 : (s1 ^ s2);
    op2_zero = (op2_i == 32'h0);
    ovf      = in_div & ~funct3_i[0] & (op1_i == 32'h8000_0000) & (op2_i == 32'hFFFF_FFFF);
    fast     = in_div & (op2_zero | ovf);
    if (op2_zero) fast_res = funct3_i[1] ? op1_i : 32'hFFFF_FFFF;
    else          fast_res = funct3_i[1] ? 32'h0 : 32'h8000_0000;
  end

  logic [32:0] sum, shifted;
  logic        ge;
  logic [31:0] hi_d, lo_d, calc_res;
  logic [63:0] prod, prod_s;

  // One iteration: hi/lo hold {product high, multiplier} or {partial remainder, quotient}.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    shifted = {hi_q, lo_q[31]};
    ge      = (shifted >= {1'b0, opb_q});
    if (f3_q[2]) begin
      hi_d = ge ? 32'(shifted - {1'b0, opb_q}) : shifted[31:0];
      lo_d = {lo_q[30:0], ge};
    end else begin
      hi_d = sum[32:1];
      lo_d = {sum[0], lo_q[31:1]};
    end
    prod   = {hi_d, lo_d};
    prod_s = neg_q ? -prod : prod;
    if (f3_q[2]) begin
      if (f3_q[1]) calc_res = neg_q ? -hi_d : hi_d;
      else         calc_res = neg_q ? -lo_d : lo_d;
    end else begin
      calc_res = (f3_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 6'd0;
      f3_q     <= 3'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opb_q    <= 32'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
      rd_q     <= 5'd0;
      waddr_q  <= 5'd0;
    end else if (flush_i) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            f3_q  <= funct3_i;
            rd_q  <= reg_waddr_i;
            hi_q  <= 32'd0;
            lo_q  <= mag1;
            opb_q <= mag2;
            neg_q <= neg_in;
            cnt_q <= 6'd0;
            if (fast) begin
              state_q  <= StDone;
              result_q <= fast_res;
              waddr_q  <= reg_waddr_i;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == 6'd31) begin
            cnt_q    <= 6'd0;
            state_q  <= StDone;
            result_q <= calc_res;
            waddr_q  <= rd_q;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_req_o    = ((state_q == StIdle) & start_i & ~flush_i) | (state_q == StCalc);
  assign busy_o         = (state_q != StIdle);
  assign result_valid_o = (state_q == StDone);
  assign reg_we_o       = (state_q == StDone);
  assign result_o       = result_q;
  assign reg_waddr_o    = waddr_q;

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Multi-cycle sequencer and datapath for the RV32M instructions: R-format opcode with funct7 = 0000001, which the base R-type decoder does not accept. It sits in EX beside the ALU. It takes the two register operands, funct3 and rd from ID/EX, runs a 32-step iterative multiply or divide, and stalls the pipeline until the result is written. It returns one registered result with a one-cycle write-enable for the writeback path.

## Interface
- No parameters. Widths are fixed: data 32, register address 5.
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  a valid M-extension instruction is in EX; held high while stalled
- funct3_i  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1_i  in  32  rs1 value
- op2_i  in  32  rs2 value
- reg_waddr_i  in  5  rd
- flush_i  in  1  pipeline flush; aborts any operation in progress
- stall_req_o  out  1  hold IF/ID/EX
- busy_o  out  1  state is not IDLE
- result_o  out  32  registered result
- result_valid_o  out  1  one-cycle result strobe
- reg_we_o  out  1  equal to result_valid_o
- reg_waddr_o  out  5  latched rd

## Operation
- States:
  - IDLE: waiting for start_i.
  - CALC: iterating, 6-bit step counter.
  - DONE: result presented for one cycle.
- IDLE with start_i=1 and flush_i=0 latches funct3, op1, op2 and rd.
  - Next state is DONE directly on a fast path: a divide or remainder op with op2=0, or a signed DIV/REM with op1=0x80000000 and op2=0xFFFFFFFF.
  - Otherwise next state is CALC with counter=0.
- CALC performs one iteration per cycle. Counter goes 0..31; at 31 the next state is DONE.
- DONE asserts result_valid_o and reg_we_o for one cycle, then goes to IDLE unconditionally.
  - start_i is ignored in DONE. It still belongs to the retiring instruction.
- Multiply:
  - Form magnitudes: signed operands are op1 for MULH/MULHSU and op2 for MULH only. Shift-add into a 64-bit accumulator.
  - Negate the product if the operand signs differ.
  - MUL returns bits [31:0]; the others return [63:32].
- Divide:
  - Restoring division on magnitudes, with a 33-bit partial remainder.
  - Quotient is negated if signs differ (DIV). Remainder takes the dividend's sign (REM).
- Fast-path results:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op1.
  - Signed overflow: DIV → 0x80000000; REM → 0.
- flush_i=1 forces IDLE on the next edge from any state.
  - No result_valid_o is produced for the aborted operation.
  - flush_i overrides start_i in IDLE.
- Reset forces IDLE. result_o, reg_waddr_o, the counter and all strobes go to 0 immediately. An operation in progress is discarded.

## Timing
- Start is accepted at edge T, where start_i is sampled high in IDLE.
- Normal path: CALC covers T+1..T+32. result_valid_o is high for the cycle after edge T+33, i.e. 33 cycles of latency.
- Fast path: result_valid_o is high the cycle after edge T+1.
- stall_req_o is combinational: (IDLE & start_i & ~flush_i) | CALC.
  - It is 0 in DONE, so the pipeline advances in the same cycle the result is written.
- busy_o = (state != IDLE). It is registered-state based.
- result_o and reg_waddr_o update on entry to DONE and hold until the next DONE.
- A back-to-back M instruction arrives with start_i high in the IDLE cycle after DONE. It is accepted there, so there is no bubble beyond that cycle.

## Test plan
- MUL:
  - Stimulus: op1=7, op2=0xFFFFFFFD (−3), start pulse held through stall.
  - Response: stall_req_o high for 33 cycles; result_o=0xFFFFFFEB with reg_we_o=1 at T+33; rd echoed on reg_waddr_o.
- MULHU and MULHSU:
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV/REM signed:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF, each at T+33.
  - DIVU 100/7 → 14.
- Fast paths:
  - DIVU 5/0 → 0xFFFFFFFF at T+1.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1; stall_req_o high for exactly 1 cycle.
- Flush and restart:
  - Stimulus: flush_i at CALC counter=10.
  - Response: no result_valid_o; busy_o=0 the following cycle.
  - A new DIVU 9/3 started next cycle returns 3 at its own T+33.
- Reset and back-to-back:
  - rst_n low mid-CALC → all outputs 0 asynchronously; state IDLE after release.
  - Two consecutive MULs → two single-cycle reg_we_o strobes, 34 cycles apart.
